// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the fetch/data SRAM arbiter: response source encoding and SRAM timing.
package sram_arbiter_pkg;

    typedef enum logic {
        SrcInst = 1'b0,
        SrcData = 1'b1
    } rsp_src_e;

    // The response path assumes the macro returns read data exactly one cycle after enable.
    localparam int unsigned SramRdLat = 1;

    function automatic logic [3:0] write_mask(input logic is_write, input logic [3:0] strobe);
        return is_write ? strobe : 4'h0;
    endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data accesses.
// Data wins ties; a streak counter forces an inst grant after STARVE_LIMIT data grants.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        inst_cancel,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic        sram_en,
    output logic [3:0]  sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata
);

    localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

    logic             grant_data;
    logic             grant_inst;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic             rsp_valid_q, rsp_valid_d;
    rsp_src_e         rsp_src_q, rsp_src_d;
    logic             rsp_cancel_q, rsp_cancel_d;

    // Grants are gated by reset so nothing reaches the macro while reset is held.
    always_comb begin
        grant_data = !reset && data_req && !(inst_req && (streak_q == Limit));
        grant_inst = !reset && inst_req && !grant_data;
    end

    always_comb begin
        inst_addr_ok = grant_inst;
        data_addr_ok = grant_data;
        sram_en      = grant_data || grant_inst;
        sram_addr    = grant_data ? data_addr : inst_addr;
        sram_we      = grant_data ? write_mask(data_wr, data_wstrb) : 4'h0;
        sram_wdata   = grant_data ? data_wdata : 32'h0;
    end

    always_comb begin
        streak_d = '0;
        if (grant_data && inst_req) begin
            streak_d = (streak_q == Limit) ? Limit : streak_q + CNT_W'(1);
        end
        rsp_valid_d  = sram_en;
        rsp_src_d    = grant_data ? SrcData : SrcInst;
        rsp_cancel_d = grant_inst && inst_cancel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q     <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_src_q    <= SrcInst;
            rsp_cancel_q <= 1'b0;
        end else begin
            streak_q     <= streak_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_src_q    <= rsp_src_d;
            rsp_cancel_q <= rsp_cancel_d;
        end
    end

    // A response still in flight when reset rises is swallowed here.
    always_comb begin
        data_data_ok = !reset && rsp_valid_q && (rsp_src_q == SrcData);
        inst_data_ok = !reset && rsp_valid_q && (rsp_src_q == SrcInst)
                       && !rsp_cancel_q && !inst_cancel;
        data_rdata   = sram_rdata;
        inst_rdata   = sram_rdata;
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic against a cycle-level
// reference model with its own copy of memory contents.
module tb_sram_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned WORDS = 4096;

    logic        clk;
    logic        reset;
    logic        inst_req, inst_cancel, data_req, data_wr;
    logic [31:0] inst_addr, data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr, sram_wdata, sram_rdata;

    int checks;
    int failures;

    // Environment SRAM and the model's independent copy of its contents.
    logic [31:0] sram_mem [WORDS];
    logic [31:0] ref_mem  [WORDS];

    // Model state: pending response and current data-grant streak.
    int unsigned m_streak;
    logic        m_valid, m_src_data, m_cancel, m_is_read;
    logic [31:0] m_word;

    sram_arbiter #(
        .STARVE_LIMIT(LIMIT),
        .CNT_W       (4)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_cancel (inst_cancel),
        .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_wstrb  (data_wstrb),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .data_rdata  (data_rdata),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .sram_rdata  (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_we[b]) sram_mem[sram_addr[13:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr[13:2]];
            end
        end
    end

    function automatic int widx(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    function automatic logic [31:0] init_word(input int i);
        return 32'h1000_0000 ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    // Returns {grant_data, grant_inst} for the current inputs and model state.
    function automatic logic [1:0] model_grants();
        logic gd;
        gd = !reset && data_req && !(inst_req && (m_streak == LIMIT));
        return {gd, !reset && inst_req && !gd};
    endfunction

    task automatic drive_idle();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        inst_cancel = 1'b0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
    endtask

    // Advance one clock and update the model from the inputs that were applied.
    task automatic tick();
        logic [1:0] g;
        g = model_grants();
        @(posedge clk);
        if (reset) begin
            m_streak = 0;
            m_valid  = 1'b0;
            m_cancel = 1'b0;
            m_src_data = 1'b0;
        end else begin
            m_valid    = g[1] || g[0];
            m_src_data = g[1];
            m_cancel   = g[0] && inst_cancel;
            m_is_read  = g[0] || (g[1] && !data_wr);
            if (g[1] && data_wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (data_wstrb[b]) ref_mem[widx(data_addr)][8*b +: 8] = data_wdata[8*b +: 8];
                end
            end else if (g[1]) begin
                m_word = ref_mem[widx(data_addr)];
            end else if (g[0]) begin
                m_word = ref_mem[widx(inst_addr)];
            end
            m_streak = (g[1] && inst_req) ? ((m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1) : 0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        inst_req = 1'b1;
        data_req = 1'b1;
        inst_addr = 32'h1C00_0000;
        data_addr = 32'h1C00_1000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if ({sram_en, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs: got en/iaok/daok/idok/ddok=%b want 00000",
                         {sram_en, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
            end
            tick();
        end
        reset = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++;
        if ({sram_en, inst_data_ok, data_data_ok} !== 3'b0) begin
            failures++;
            $display("FAIL post_reset_idle: got en/idok/ddok=%b want 000",
                     {sram_en, inst_data_ok, data_data_ok});
        end
        tick();
    endtask

    task automatic test_inst_only();
        logic [31:0] exp_w [3];
        for (int i = 0; i < 4; i++) begin
            drive_idle();
            if (i < 3) begin
                inst_req  = 1'b1;
                inst_addr = 32'h1C00_0000 + 32'(4 * i);
            end
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || sram_we !== 4'h0) begin
                    failures++;
                    $display("FAIL inst_only_grant[%0d]: got iaok=%b daok=%b we=%h want 1 0 0",
                             i, inst_addr_ok, data_addr_ok, sram_we);
                end
                checks++;
                if (sram_addr !== 32'h1C00_0000 + 32'(4 * i)) begin
                    failures++;
                    $display("FAIL inst_only_addr[%0d]: got %h want %h", i, sram_addr,
                             32'h1C00_0000 + 32'(4 * i));
                end
                exp_w[i] = ref_mem[widx(inst_addr)];
            end
            if (i > 0) begin
                checks++;
                if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0 || inst_rdata !== exp_w[i-1]) begin
                    failures++;
                    $display("FAIL inst_only_rsp[%0d]: got idok=%b ddok=%b rdata=%h want 1 0 %h",
                             i, inst_data_ok, data_data_ok, inst_rdata, exp_w[i-1]);
                end
            end
            tick();
        end
    endtask

    task automatic test_conflict();
        logic [31:0] exp_w;
        drive_idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0100;
        data_req  = 1'b1;
        data_addr = 32'h1C00_1000;
        @(negedge clk);
        checks++;
        if (data_addr_ok !== 1'b1 || inst_addr_ok !== 1'b0 || sram_addr !== 32'h1C00_1000) begin
            failures++;
            $display("FAIL conflict_grant: got daok=%b iaok=%b addr=%h want 1 0 1c001000",
                     data_addr_ok, inst_addr_ok, sram_addr);
        end
        exp_w = ref_mem[widx(32'h1C00_1000)];
        tick();
        data_req = 1'b0;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1 || inst_addr_ok !== 1'b1 || data_rdata !== exp_w) begin
            failures++;
            $display("FAIL conflict_followup: got ddok=%b iaok=%b rdata=%h want 1 1 %h",
                     data_data_ok, inst_addr_ok, data_rdata, exp_w);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b1 || data_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL conflict_inst_rsp: got idok=%b ddok=%b want 1 0", inst_data_ok,
                     data_data_ok);
        end
        tick();
    endtask

    task automatic test_starvation();
        logic want_i, want_iok;
        for (int k = 1; k <= 11; k++) begin
            drive_idle();
            if (k <= 10) begin
                inst_req  = 1'b1;
                data_req  = 1'b1;
                inst_addr = 32'h1C00_0300 + 32'(4 * k);
                data_addr = 32'h1C00_0200 + 32'(4 * k);
            end
            @(negedge clk);
            if (k <= 10) begin
                want_i = (k % 5 == 0);
                checks++;
                if (inst_addr_ok !== want_i || data_addr_ok !== !want_i) begin
                    failures++;
                    $display("FAIL starve_grant[%0d]: got iaok=%b daok=%b want %b %b", k,
                             inst_addr_ok, data_addr_ok, want_i, !want_i);
                end
            end
            if (k >= 2) begin
                want_iok = ((k - 1) % 5 == 0);
                checks++;
                if (inst_data_ok !== want_iok || data_data_ok !== !want_iok) begin
                    failures++;
                    $display("FAIL starve_rsp[%0d]: got idok=%b ddok=%b want %b %b", k,
                             inst_data_ok, data_data_ok, want_iok, !want_iok);
                end
            end
            tick();
        end
    endtask

    task automatic test_write();
        logic [31:0] orig;
        drive_idle();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h1C00_2000;
        data_wdata = 32'hA5A5_1234;
        orig = ref_mem[widx(32'h1C00_2000)];
        @(negedge clk);
        checks++;
        if (sram_we !== 4'b0011 || sram_wdata !== 32'hA5A5_1234 || data_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL write_drive: got we=%b wdata=%h daok=%b want 0011 a5a51234 1",
                     sram_we, sram_wdata, data_addr_ok);
        end
        tick();
        data_wr    = 1'b0;
        data_wstrb = 4'h0;
        data_wdata = 32'h0;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1 || sram_we !== 4'h0) begin
            failures++;
            $display("FAIL write_done: got ddok=%b we=%b want 1 0000", data_data_ok, sram_we);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1 || data_rdata !== {orig[31:16], 16'h1234}) begin
            failures++;
            $display("FAIL write_readback: got ddok=%b rdata=%h want 1 %h", data_data_ok,
                     data_rdata, {orig[31:16], 16'h1234});
        end
        tick();
    endtask

    task automatic test_cancel();
        logic [31:0] exp_w;
        // Late cancel kills the response arriving in the same cycle.
        drive_idle();
        inst_req  = 1'b1;
        inst_addr = 32'h1C00_0040;
        tick();
        drive_idle();
        inst_cancel = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b0) begin
            failures++;
            $display("FAIL cancel_late: got idok=%b want 0", inst_data_ok);
        end
        tick();
        // Early cancel rides along with the grant; a fresh grant right behind still completes.
        drive_idle();
        inst_req    = 1'b1;
        inst_cancel = 1'b1;
        inst_addr   = 32'h1C00_0044;
        @(negedge clk);
        checks++;
        if (inst_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL cancel_early_grant: got iaok=%b want 1", inst_addr_ok);
        end
        tick();
        inst_cancel = 1'b0;
        inst_addr   = 32'h1C00_0048;
        exp_w = ref_mem[widx(32'h1C00_0048)];
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b0 || inst_addr_ok !== 1'b1) begin
            failures++;
            $display("FAIL cancel_early_rsp: got idok=%b iaok=%b want 0 1", inst_data_ok,
                     inst_addr_ok);
        end
        tick();
        drive_idle();
        @(negedge clk);
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== exp_w) begin
            failures++;
            $display("FAIL cancel_next_rsp: got idok=%b rdata=%h want 1 %h", inst_data_ok,
                     inst_rdata, exp_w);
        end
        tick();
        // Cancel has no effect on a data response.
        data_req  = 1'b1;
        data_addr = 32'h1C00_0080;
        tick();
        drive_idle();
        inst_cancel = 1'b1;
        @(negedge clk);
        checks++;
        if (data_data_ok !== 1'b1) begin
            failures++;
            $display("FAIL cancel_data_unaffected: got ddok=%b want 1", data_data_ok);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        drive_idle();
        inst_req  = 1'b1;
        data_req  = 1'b1;
        inst_addr = 32'h1C00_0010;
        data_addr = 32'h1C00_0020;
        for (int i = 0; i < 3; i++) tick();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({data_data_ok, inst_data_ok, sram_en, data_addr_ok, inst_addr_ok} !== 5'b0) begin
            failures++;
            $display("FAIL midflight_reset: got ddok/idok/en/daok/iaok=%b want 00000",
                     {data_data_ok, inst_data_ok, sram_en, data_addr_ok, inst_addr_ok});
        end
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (data_addr_ok !== (k < 5) || inst_addr_ok !== (k == 5)) begin
                failures++;
                $display("FAIL midflight_streak[%0d]: got daok=%b iaok=%b want %b %b", k,
                         data_addr_ok, inst_addr_ok, k < 5, k == 5);
            end
            if (k == 1) begin
                checks++;
                if (data_data_ok !== 1'b0) begin
                    failures++;
                    $display("FAIL midflight_dropped: got ddok=%b want 0", data_data_ok);
                end
            end
            tick();
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        logic [1:0] g;
        logic       exp_dok, exp_iok;
        reset = 1'b1;
        drive_idle();
        tick();
        reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            reset       = ($urandom_range(0, 59) == 0);
            inst_req    = ($urandom_range(0, 3) != 0);
            data_req    = ($urandom_range(0, 1) != 0);
            inst_cancel = ($urandom_range(0, 4) == 0);
            data_wr     = ($urandom_range(0, 4) < 2);
            data_wstrb  = 4'($urandom);
            inst_addr   = 32'h1C00_0000 + 32'($urandom_range(0, 31) * 4);
            data_addr   = 32'h1C00_0000 + 32'($urandom_range(0, 31) * 4);
            data_wdata  = $urandom;
            g       = model_grants();
            exp_dok = !reset && m_valid && m_src_data;
            exp_iok = !reset && m_valid && !m_src_data && !m_cancel && !inst_cancel;
            @(negedge clk);
            checks++;
            if ({data_addr_ok, inst_addr_ok} !== g || sram_en !== (g != 2'b00)) begin
                failures++;
                $display("FAIL rand_grant[%0d]: got daok/iaok=%b en=%b want %b %b", n,
                         {data_addr_ok, inst_addr_ok}, sram_en, g, g != 2'b00);
            end
            checks++;
            if (sram_we !== ((g[1] && data_wr) ? data_wstrb : 4'h0)
                || sram_wdata !== (g[1] ? data_wdata : 32'h0)) begin
                failures++;
                $display("FAIL rand_wdrive[%0d]: got we=%b wdata=%h", n, sram_we, sram_wdata);
            end
            if (g != 2'b00) begin
                checks++;
                if (sram_addr !== (g[1] ? data_addr : inst_addr)) begin
                    failures++;
                    $display("FAIL rand_addr[%0d]: got %h want %h", n, sram_addr,
                             g[1] ? data_addr : inst_addr);
                end
            end
            checks++;
            if (data_data_ok !== exp_dok || inst_data_ok !== exp_iok) begin
                failures++;
                $display("FAIL rand_rsp[%0d]: got ddok=%b idok=%b want %b %b", n, data_data_ok,
                         inst_data_ok, exp_dok, exp_iok);
            end
            if ((exp_dok || exp_iok) && m_is_read) begin
                checks++;
                if ((exp_dok ? data_rdata : inst_rdata) !== m_word) begin
                    failures++;
                    $display("FAIL rand_rdata[%0d]: got %h want %h", n,
                             exp_dok ? data_rdata : inst_rdata, m_word);
                end
            end
            tick();
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        m_streak   = 0;
        m_valid    = 1'b0;
        m_src_data = 1'b0;
        m_cancel   = 1'b0;
        m_is_read  = 1'b0;
        m_word     = 32'h0;
        for (int i = 0; i < WORDS; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_inst_only();
        test_conflict();
        test_starvation();
        test_write();
        test_cancel();
        test_reset_midflight();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
